ysyx_22041207_rd_arbiter: RTL and testbench

Parametrised N-master read-channel arbiter. It sits between several read requesters (IF, MEM, and later DMA/debug) and the single read port of the AXI master bridge. It has fixed-priority and round-robin modes, a registered per-transaction grant, and address/size capture at grant so the slave sees a stable request. Exactly one read transaction is outstanding at a time.

---
 rtl/ysyx_22041207_rd_arbiter.sv | 136 +++++++++++++
 tb/tb_ysyx_22041207_rd_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041207_rd_arbiter.sv
// N-master read-channel arbiter in front of the single read port of the AXI master bridge.
// Latency: 1 cycle from a request seen in IDLE to s_r_valid_o; minimum 3-cycle transaction; one IDLE cycle between transactions.
// Backpressure: handshakes pass combinationally between granted master and bridge; losers hold valid until a later IDLE.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   m_r_valid_i/m_r_ready_o     per-master address request / accept
//   m_r_addr_i, m_r_size_i      per-master flattened address and size (master 0 at the low end)
//   m_data_read_o               read data broadcast to all masters
//   m_r_data_valid_o            per-master read data valid (granted master only)
//   m_r_data_ready_i            per-master read data accept
//   s_r_*                       request / data channel toward the bridge
//   grant_o, busy_o             one-hot owner (zero in IDLE), non-IDLE indicator
module ysyx_22041207_rd_arbiter #(
   parameter int NUM_M         = 2,
   parameter int RW_ADDR_WIDTH = 64,
   parameter int RW_DATA_WIDTH = 64,
   parameter int RR_MODE       = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_M-1:0]           m_r_valid_i,
   output logic [NUM_M-1:0]           m_r_ready_o,
   input  logic [NUM_M*RW_ADDR_WIDTH-1:0] m_r_addr_i,
   input  logic [NUM_M*8-1:0]         m_r_size_i,
   output logic [RW_DATA_WIDTH-1:0]   m_data_read_o,
   output logic [NUM_M-1:0]           m_r_data_valid_o,
   input  logic [NUM_M-1:0]           m_r_data_ready_i,
   output logic                       s_r_valid_o,
   input  logic                       s_r_ready_i,
   output logic [RW_ADDR_WIDTH-1:0]   s_r_addr_o,
   output logic [7:0]                 s_r_size_o,
   input  logic [RW_DATA_WIDTH-1:0]   s_data_read_i,
   input  logic                       s_r_data_valid_i,
   output logic                       s_r_data_ready_o,
   output logic [NUM_M-1:0]           grant_o,
   output logic                       busy_o
);

   localparam int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t                   state_q;
   logic [NUM_M-1:0]         grant_q;
   logic [PTR_W-1:0]         gidx_q;
   logic [PTR_W-1:0]         rr_ptr_q;
   logic [RW_ADDR_WIDTH-1:0] addr_q;
   logic [7:0]               size_q;

   logic [PTR_W-1:0]         win_idx_d;
   logic                     win_vld_d;
   logic [PTR_W-1:0]         rr_ptr_d;
   logic                     data_done;
   int                       cand;

   // Scan from the highest offset down so the last hit is the first set
   // index at or after the start point (rr_ptr in RR mode, 0 otherwise).
   always_comb begin
      win_idx_d = '0;
      win_vld_d = 1'b0;
      cand      = 0;
      for (int k = NUM_M - 1; k >= 0; k--) begin
         if (RR_MODE != 0) begin
            cand = (int'(rr_ptr_q) + k) % NUM_M;
         end else begin
            cand = k;
         end
         if (m_r_valid_i[cand]) begin
            win_idx_d = PTR_W'(cand);
            win_vld_d = 1'b1;
         end
      end
   end

   assign rr_ptr_d  = (gidx_q == PTR_W'(NUM_M - 1)) ? '0 : gidx_q + PTR_W'(1);
   assign data_done = (state_q == S_DATA) && s_r_data_valid_i && m_r_data_ready_i[gidx_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         gidx_q   <= '0;
         rr_ptr_q <= '0;
         addr_q   <= '0;
         size_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (win_vld_d) begin
                  state_q <= S_ADDR;
                  grant_q <= NUM_M'(1) << win_idx_d;
                  gidx_q  <= win_idx_d;
                  addr_q  <= m_r_addr_i[win_idx_d*RW_ADDR_WIDTH +: RW_ADDR_WIDTH];
                  size_q  <= m_r_size_i[win_idx_d*8 +: 8];
               end
            end
            S_ADDR: begin
               if (s_r_ready_i) begin
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (data_done) begin
                  state_q <= S_IDLE;
                  grant_q <= '0;
                  if (RR_MODE != 0) begin
                     rr_ptr_q <= rr_ptr_d;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

   // The bridge sees only the captured copy, so the master may change or
   // drop its request while the address phase is stalled.
   assign s_r_valid_o      = (state_q == S_ADDR);
   assign s_r_addr_o       = (state_q == S_ADDR) ? addr_q : '0;
   assign s_r_size_o       = (state_q == S_ADDR) ? size_q : '0;
   assign m_r_ready_o      = ((state_q == S_ADDR) && s_r_ready_i) ? grant_q : '0;
   assign m_r_data_valid_o = ((state_q == S_DATA) && s_r_data_valid_i) ? grant_q : '0;
   assign s_r_data_ready_o = (state_q == S_DATA) && m_r_data_ready_i[gidx_q];
   assign m_data_read_o    = s_data_read_i;
   assign grant_o          = grant_q;
   assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_ysyx_22041207_rd_arbiter.sv
// Directed bench: fixed-priority 2-master instance (a_*) and round-robin 4-master instance (b_*).
// Inputs are driven and outputs sampled on the falling edge; the DUTs update on the rising edge.
// A shared asynchronous reset is pulsed between edges in the middle of a data phase.
module tb_ysyx_22041207_rd_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // instance A: NUM_M=2, fixed priority
   logic [1:0]   a_m_valid, a_m_ready, a_m_dvalid, a_m_dready, a_grant;
   logic [127:0] a_m_addr;
   logic [15:0]  a_m_size;
   logic [63:0]  a_m_data, a_s_addr, a_s_data;
   logic         a_s_valid, a_s_ready, a_s_dvalid, a_s_dready, a_busy;
   logic [7:0]   a_s_size;

   // instance B: NUM_M=4, round-robin
   logic [3:0]   b_m_valid, b_m_ready, b_m_dvalid, b_m_dready, b_grant;
   logic [255:0] b_m_addr;
   logic [31:0]  b_m_size;
   logic [63:0]  b_m_data, b_s_addr, b_s_data;
   logic         b_s_valid, b_s_ready, b_s_dvalid, b_s_dready, b_busy;
   logic [7:0]   b_s_size;

   ysyx_22041207_rd_arbiter #(.NUM_M(2), .RR_MODE(0)) u_a (
      .clk(clk), .rst(rst),
      .m_r_valid_i(a_m_valid), .m_r_ready_o(a_m_ready),
      .m_r_addr_i(a_m_addr), .m_r_size_i(a_m_size),
      .m_data_read_o(a_m_data), .m_r_data_valid_o(a_m_dvalid),
      .m_r_data_ready_i(a_m_dready),
      .s_r_valid_o(a_s_valid), .s_r_ready_i(a_s_ready),
      .s_r_addr_o(a_s_addr), .s_r_size_o(a_s_size),
      .s_data_read_i(a_s_data), .s_r_data_valid_i(a_s_dvalid),
      .s_r_data_ready_o(a_s_dready),
      .grant_o(a_grant), .busy_o(a_busy)
   );

   ysyx_22041207_rd_arbiter #(.NUM_M(4), .RR_MODE(1)) u_b (
      .clk(clk), .rst(rst),
      .m_r_valid_i(b_m_valid), .m_r_ready_o(b_m_ready),
      .m_r_addr_i(b_m_addr), .m_r_size_i(b_m_size),
      .m_data_read_o(b_m_data), .m_r_data_valid_o(b_m_dvalid),
      .m_r_data_ready_i(b_m_dready),
      .s_r_valid_o(b_s_valid), .s_r_ready_i(b_s_ready),
      .s_r_addr_o(b_s_addr), .s_r_size_o(b_s_size),
      .s_data_read_i(b_s_data), .s_r_data_valid_i(b_s_dvalid),
      .s_r_data_ready_o(b_s_dready),
      .grant_o(b_grant), .busy_o(b_busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      a_m_valid = '0; a_m_dready = '0; a_m_addr = '0; a_m_size = '0;
      a_s_ready = 1'b0; a_s_data = '0; a_s_dvalid = 1'b0;
      b_m_valid = '0; b_m_dready = '0; b_m_addr = '0; b_m_size = '0;
      b_s_ready = 1'b0; b_s_data = '0; b_s_dvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         b_m_addr[i*64 +: 64] = 64'h1000 * 64'(i + 1);
         b_m_size[i*8 +: 8]   = 8'(i + 1);
      end

      // ---------------- reset state ----------------
      tick();
      a_s_data = 64'h1234_5678;
      #1;
      check("rst_busy",   64'(a_busy),    64'd0);
      check("rst_grant",  64'(a_grant),   64'd0);
      check("rst_svalid", 64'(a_s_valid), 64'd0);
      check("rst_rdata",  a_m_data,       64'h1234_5678);
      tick();
      rst = 1'b0;

      // ---------------- fixed priority, both masters valid ----------------
      a_m_addr   = {64'h8000_0100, 64'h8000_0000};
      a_m_size   = {8'd3, 8'd2};
      a_m_valid  = 2'b11;
      a_s_ready  = 1'b1;
      a_s_dvalid = 1'b1;
      a_m_dready = 2'b11;
      tick();                                           // IDLE -> ADDR
      check("fp_g0",      64'(a_grant),   64'b01);
      check("fp_sv0",     64'(a_s_valid), 64'd1);
      check("fp_addr0",   a_s_addr,       64'h8000_0000);
      check("fp_size0",   64'(a_s_size),  64'd2);
      check("fp_mrdy0",   64'(a_m_ready), 64'b01);
      tick();                                           // DATA
      check("fp_dv0",     64'(a_m_dvalid), 64'b01);
      check("fp_sdrdy0",  64'(a_s_dready), 64'd1);
      tick();                                           // IDLE gap
      check("fp_gap_busy",  64'(a_busy),  64'd0);
      check("fp_gap_grant", 64'(a_grant), 64'd0);
      check("fp_gap_sv",    64'(a_s_valid), 64'd0);
      a_m_valid = 2'b10;                                // master 0 done
      tick();
      check("fp_g1",      64'(a_grant),   64'b10);
      check("fp_addr1",   a_s_addr,       64'h8000_0100);
      tick();
      check("fp_dv1",     64'(a_m_dvalid), 64'b10);
      a_m_valid = 2'b00;
      tick();
      check("fp_end_busy", 64'(a_busy), 64'd0);

      // ---------------- address stability + data backpressure ----------------
      a_m_addr   = {64'h100, 64'h0};
      a_m_valid  = 2'b10;
      a_s_ready  = 1'b0;
      a_s_dvalid = 1'b0;
      a_m_dready = 2'b00;
      tick();                                           // ADDR, stalled
      check("st_grant", 64'(a_grant), 64'b10);
      check("st_mrdy",  64'(a_m_ready), 64'b00);
      a_m_addr  = {64'h200, 64'h0};
      a_m_valid = 2'b00;
      for (int c = 0; c < 3; c++) begin
         check("st_addr_hold", a_s_addr, 64'h100);
         check("st_sv_hold",   64'(a_s_valid), 64'd1);
         tick();
      end
      a_s_ready = 1'b1;
      #1;
      check("st_mrdy_acc", 64'(a_m_ready), 64'b10);
      tick();                                           // DATA
      a_s_ready  = 1'b0;
      a_s_dvalid = 1'b1;
      a_s_data   = 64'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         a_m_dready = (c == 2) ? 2'b10 : 2'b01;         // non-granted ready must not matter
         #1;
         check("bp_busy",  64'(a_busy),     64'd1);
         check("bp_sdrdy", 64'(a_s_dready), (c == 2) ? 64'd1 : 64'd0);
         check("bp_dv",    64'(a_m_dvalid), 64'b10);
         check("bp_rdata", a_m_data,        64'hDEAD_BEEF);
         tick();
      end
      check("bp_done", 64'(a_busy), 64'd0);
      a_s_dvalid = 1'b0;
      a_m_dready = 2'b00;

      // ---------------- round-robin, four masters always valid ----------------
      b_m_valid  = 4'b1111;
      b_s_ready  = 1'b1;
      b_s_dvalid = 1'b1;
      b_m_dready = 4'b1111;
      for (int t = 0; t < 9; t++) begin
         tick();                                        // ADDR
         check("rr_grant", 64'(b_grant), 64'(1) << (t % 4));
         check("rr_addr",  b_s_addr, 64'h1000 * 64'((t % 4) + 1));
         check("rr_size",  64'(b_s_size), 64'((t % 4) + 1));
         tick();                                        // DATA
         check("rr_dv",    64'(b_m_dvalid), 64'(1) << (t % 4));
         tick();                                        // IDLE
         check("rr_idle",  64'(b_busy), 64'd0);
      end
      // 10th transaction goes to master 1; reset it mid-DATA
      tick();
      check("rr_g10", 64'(b_grant), 64'b0010);
      tick();                                           // DATA
      #2;
      rst = 1'b1;
      #1;
      check("ar_busy",  64'(b_busy),    64'd0);
      check("ar_grant", 64'(b_grant),   64'd0);
      check("ar_sv",    64'(b_s_valid), 64'd0);
      check("ar_sdrdy", 64'(b_s_dready), 64'd0);
      check("ar_dv",    64'(b_m_dvalid), 64'd0);
      b_m_valid = 4'b0101;
      #1;
      rst = 1'b0;
      tick();                                           // rr_ptr cleared: master 0 wins
      check("ar_g_after", 64'(b_grant), 64'b0001);
      tick();
      tick();                                           // IDLE, rr_ptr = 1
      b_m_valid = 4'b0100;
      tick();
      check("ar_g_m2",  64'(b_grant),   64'b0100);
      check("ar_mrdy2", 64'(b_m_ready), 64'b0100);
      check("ar_addr2", b_s_addr,       64'h3000);
      b_m_valid = 4'b0000;
      tick();
      tick();
      check("ar_end", 64'(b_busy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
